ioctl_dn_router: RTL and testbench

IOCTL_DN_ROUTER -- requirements
Module: ioctl_dn_router

---
 rtl/ioctl_dn_pkg.sv | 23 ++
 rtl/ioctl_dn_router_if.sv | 31 +++
 rtl/dn_fifo.sv | 58 +++++
 rtl/ioctl_dn_router.sv | 129 ++++++++++++
 tb/tb_ioctl_dn_router.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ioctl_dn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_dn_pkg
// Brief    : Shared state encoding and default slot map for the download router.
// Revision : 1.0 - initial release
// ============================================================================
package ioctl_dn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dn_state_t;

    // Entry [i] belongs to download index i (index 0 is the least significant word).
    localparam logic [3:0][31:0] SLOT_BASE  = {32'h0000_2000, 32'h0000_1000,
                                               32'h0000_0800, 32'h0000_0000};
    localparam logic [3:0][31:0] SLOT_LIMIT = {32'h0000_3FFF, 32'h0000_3FFF,
                                               32'h0000_3FFF, 32'h0000_3FFF};

endpackage
`default_nettype wire

// File: rtl/ioctl_dn_router_if.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_dn_router_if
// Brief    : HPS download byte stream in, target memory write bus out.
// Revision : 1.0 - initial release
// ============================================================================
interface ioctl_dn_router_if #(
    parameter int AW = 14,
    parameter int MW = 25
) ();
    logic          dn_go;
    logic          dn_wr;
    logic [AW-1:0] dn_addr;
    logic [7:0]    dn_data;
    logic [7:0]    dn_idx;
    logic [MW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr;
    logic          mem_ready;

    modport master (
        input  dn_go, dn_wr, dn_addr, dn_data, dn_idx, mem_ready,
        output mem_addr, mem_data, mem_wr
    );

    modport slave (
        output dn_go, dn_wr, dn_addr, dn_data, dn_idx, mem_ready,
        input  mem_addr, mem_data, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/dn_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dn_fifo
// Brief    : Small register FIFO with a registered head word and flush.
// Revision : 1.0 - initial release
// ============================================================================
module dn_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [W-1:0]      head
);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + PW'(1);
            end
            if (pop) r_rd <= r_rd + PW'(1);
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign full  = (r_cnt == C_FULL);
    assign empty = (r_cnt == '0);
    assign head  = r_mem[r_rd];
endmodule
`default_nettype wire

// File: rtl/ioctl_dn_router.sv
`default_nettype none
// ============================================================================
// Module   : ioctl_dn_router
// Brief    : Maps HPS download bytes onto per-index memory windows via a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ioctl_dn_router
    import ioctl_dn_pkg::*;
#(
    parameter int                     AW        = 14,
    parameter int                     MW        = 25,
    parameter int                     NSLOT     = 4,
    parameter int                     DEPTH     = 4,
    parameter logic [NSLOT-1:0][31:0] BASE_MAP  = ioctl_dn_pkg::SLOT_BASE,
    parameter logic [NSLOT-1:0][31:0] LIMIT_MAP = ioctl_dn_pkg::SLOT_LIMIT
) (
    input  wire logic              clk_sys,
    input  wire logic              reset,
    ioctl_dn_router_if.master      bus,
    output logic                   busy,
    output logic                   cpu_reset_req,
    output logic                   done,
    output logic                   err_ovf,
    output logic                   err_range,
    output logic [AW:0]            byte_cnt
);
    localparam int SIW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    dn_state_t       r_state;
    logic            r_go;
    logic            r_go_d;
    logic [7:0]      r_idx;

    logic            w_rise;
    logic            w_fall;
    logic [SIW-1:0]  w_slot;
    logic            w_mapped;
    logic [MW-1:0]   w_addr;
    logic            w_wr_load;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic [MW+7:0]   w_head;

    assign w_rise    = r_go & ~r_go_d;
    assign w_fall    = ~r_go & r_go_d;
    assign w_slot    = r_idx[SIW-1:0];
    assign w_mapped  = (int'(r_idx) < NSLOT) && (32'(bus.dn_addr) <= LIMIT_MAP[w_slot]);
    assign w_addr    = MW'(BASE_MAP[w_slot]) + MW'(bus.dn_addr);
    assign w_wr_load = (r_state == ST_LOAD) && bus.dn_wr;
    assign w_pop     = bus.mem_wr && bus.mem_ready;
    assign w_push    = w_wr_load && w_mapped && (!w_full || w_pop);
    assign w_flush   = (r_state == ST_IDLE) && w_rise;

    // Gating on busy keeps the write strobe dead outside LOAD/DRAIN.
    assign bus.mem_wr   = busy && !w_empty;
    assign bus.mem_addr = w_head[MW+7:8];
    assign bus.mem_data = w_head[7:0];

    dn_fifo #(
        .W     (MW + 8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_addr, bus.dn_data}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_go          <= 1'b0;
            r_go_d        <= 1'b0;
            r_idx         <= '0;
            busy          <= 1'b0;
            cpu_reset_req <= 1'b0;
            done          <= 1'b0;
            err_ovf       <= 1'b0;
            err_range     <= 1'b0;
            byte_cnt      <= '0;
        end else begin
            r_go   <= bus.dn_go;
            r_go_d <= r_go;
            done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state       <= ST_LOAD;
                        r_idx         <= bus.dn_idx;
                        busy          <= 1'b1;
                        cpu_reset_req <= (bus.dn_idx == 8'd0);
                        err_ovf       <= 1'b0;
                        err_range     <= 1'b0;
                        byte_cnt      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_wr_load) begin
                        if (!w_mapped)
                            err_range <= 1'b1;
                        else if (w_push) begin
                            if (byte_cnt != '1) byte_cnt <= byte_cnt + (AW+1)'(1);
                        end else
                            err_ovf <= 1'b1;
                    end
                    if (w_fall) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state       <= ST_DONE;
                        busy          <= 1'b0;
                        cpu_reset_req <= 1'b0;
                        done          <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ioctl_dn_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_ioctl_dn_router
// Brief    : Directed scoreboard bench for the download router.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ioctl_dn_router;
    localparam int AW = 14;
    localparam int MW = 25;
    localparam logic [3:0][31:0] TB_LIMIT = {32'h0000_00FF, 32'h0000_3FFF,
                                             32'h0000_3FFF, 32'h0000_3FFF};

    logic          clk = 1'b0;
    logic          rst;
    logic          busy, cpu_reset_req, done, err_ovf, err_range;
    logic [AW:0]   byte_cnt;

    int            n_cmp = 0;
    int            n_err = 0;
    int            n_wr  = 0;
    logic [MW+7:0] exp_q [$];

    ioctl_dn_router_if #(.AW(AW), .MW(MW)) bus ();

    ioctl_dn_router #(
        .AW        (AW),
        .MW        (MW),
        .NSLOT     (4),
        .DEPTH     (4),
        .LIMIT_MAP (TB_LIMIT)
    ) dut (
        .clk_sys       (clk),
        .reset         (rst),
        .bus           (bus),
        .busy          (busy),
        .cpu_reset_req (cpu_reset_req),
        .done          (done),
        .err_ovf       (err_ovf),
        .err_range     (err_range),
        .byte_cnt      (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Any completed transfer is scored against the oldest expected write.
    task automatic step();
        if (bus.mem_wr && bus.mem_ready) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_wr: observed addr %0h expected no write", bus.mem_addr);
                end
            end else
                check("mem_beat", 64'({bus.mem_addr, bus.mem_data}), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.dn_idx = idx;
        bus.dn_go  = 1'b1;
        for (int i = 0; i < 8 && !busy; i++) step();
        check("load_entry_busy", 64'(busy), 64'd1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [7:0] d,
                        input bit ok, input logic [MW-1:0] exp_addr);
        bus.dn_wr   = 1'b1;
        bus.dn_addr = a;
        bus.dn_data = d;
        if (ok) exp_q.push_back({exp_addr, d});
        step();
        bus.dn_wr = 1'b0;
    endtask

    task automatic end_dl();
        bus.dn_go = 1'b0;
        for (int i = 0; i < 200 && !done; i++) step();
        check("done_pulse", 64'(done), 64'd1);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.dn_go     = 1'b0;
        bus.dn_wr     = 1'b0;
        bus.dn_addr   = '0;
        bus.dn_data   = '0;
        bus.dn_idx    = '0;
        bus.mem_ready = 1'b1;
        repeat (3) step();
        check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cpu_req", 64'(cpu_reset_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_errs", 64'({err_ovf, err_range}), 64'd0);
        check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_data", 64'(bus.mem_data), 64'd0);
        rst = 1'b0;
        step();

        // Slot 1: sixteen streamed bytes land at 0x0800..0x080F.
        n_wr = 0;
        start_dl(8'd1);
        for (int i = 0; i < 16; i++)
            send(AW'(i), 8'(8'hA0 + i), 1'b1, MW'(32'h800 + i));
        end_dl();
        check("s1_byte_cnt", 64'(byte_cnt), 64'd16);
        check("s1_errs", 64'({err_ovf, err_range}), 64'd0);
        check("s1_writes", 64'(n_wr), 64'd16);

        // CPU reset request follows index 0 only.
        start_dl(8'd0);
        check("idx0_cpu_req", 64'(cpu_reset_req), 64'd1);
        send(AW'(3), 8'h5A, 1'b1, MW'(3));
        check("idx0_cpu_req_load", 64'(cpu_reset_req), 64'd1);
        end_dl();
        check("idx0_cpu_req_idle", 64'(cpu_reset_req), 64'd0);
        start_dl(8'd2);
        check("idx2_cpu_req", 64'(cpu_reset_req), 64'd0);
        send(AW'(5), 8'h77, 1'b1, MW'(32'h1005));
        end_dl();

        // Overflow: six bytes with the sink stalled, only four fit.
        n_wr = 0;
        bus.mem_ready = 1'b0;
        start_dl(8'd1);
        for (int i = 0; i < 6; i++)
            send(AW'(i), 8'(8'h30 + i), i < 4, MW'(32'h800 + i));
        check("ovf_flag", 64'(err_ovf), 64'd1);
        check("ovf_byte_cnt", 64'(byte_cnt), 64'd4);
        check("ovf_head_addr", 64'(bus.mem_addr), 64'h800);
        bus.mem_ready = 1'b1;
        end_dl();
        check("ovf_writes", 64'(n_wr), 64'd4);
        check("ovf_sticky", 64'(err_ovf), 64'd1);

        // Unmapped index, then over-limit byte in slot 3.
        n_wr = 0;
        start_dl(8'd5);
        send(AW'(0), 8'h11, 1'b0, '0);
        send(AW'(1), 8'h12, 1'b0, '0);
        check("idx5_range", 64'(err_range), 64'd1);
        check("idx5_byte_cnt", 64'(byte_cnt), 64'd0);
        end_dl();
        check("idx5_writes", 64'(n_wr), 64'd0);
        check("idx5_range_hold", 64'(err_range), 64'd1);
        start_dl(8'd3);
        check("idx3_range_clr", 64'(err_range), 64'd0);
        send(AW'(16'h00FF), 8'h21, 1'b1, MW'(32'h20FF));
        send(AW'(16'h0100), 8'h22, 1'b0, '0);
        check("idx3_range", 64'(err_range), 64'd1);
        check("idx3_byte_cnt", 64'(byte_cnt), 64'd1);
        end_dl();

        // Full FIFO: a write coinciding with a pop is still accepted.
        n_wr = 0;
        bus.mem_ready = 1'b0;
        start_dl(8'd2);
        for (int i = 0; i < 4; i++)
            send(AW'(16 + i), 8'(8'hC0 + i), 1'b1, MW'(32'h1010 + i));
        bus.mem_ready = 1'b1;
        send(AW'(20), 8'hC4, 1'b1, MW'(32'h1014));
        check("full_pop_ovf", 64'(err_ovf), 64'd0);
        check("full_pop_cnt", 64'(byte_cnt), 64'd5);
        end_dl();
        check("full_pop_writes", 64'(n_wr), 64'd5);

        // Reset mid-drain discards the remaining queued bytes.
        n_wr = 0;
        bus.mem_ready = 1'b0;
        start_dl(8'd1);
        for (int i = 0; i < 4; i++)
            send(AW'(i), 8'(8'hE0 + i), 1'b1, MW'(32'h800 + i));
        bus.mem_ready = 1'b1;
        step();
        step();
        check("pre_rst_writes", 64'(n_wr), 64'd2);
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.dn_go     = 1'b0;
        step();
        exp_q.delete();
        check("mid_rst_mem_wr", 64'(bus.mem_wr), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cnt", 64'(byte_cnt), 64'd0);
        check("mid_rst_addr", 64'(bus.mem_addr), 64'd0);
        check("mid_rst_flags", 64'({err_ovf, err_range, cpu_reset_req, done}), 64'd0);
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        n_wr = 0;
        start_dl(8'd1);
        send(AW'(32), 8'h99, 1'b1, MW'(32'h820));
        send(AW'(33), 8'h9A, 1'b1, MW'(32'h821));
        end_dl();
        check("post_rst_writes", 64'(n_wr), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
